// File: rtl/imem_rsp.sv
// Single-outstanding request/response bridge onto a synchronous SRAM.
// Optional wait states precede the one-cycle memory access; out-of-range addresses respond with an error.
module imem_rsp #(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           data_i,
    input  logic [3:0]            sel_i,
    input  logic                  we_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           data_o,
    output logic                  rsp_err_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_sel_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        MEM  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     hold_q;
    logic                  first_q;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [SEL_W-1:0]      mem_sel_q;

    logic req_hs_c;
    logic range_err_c;

    assign req_hs_c    = req_valid_i & ready_q;
    assign range_err_c = |(addr_i >> (ADDR_WIDTH + 2));

    // Next-state logic and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_hs_c) begin
                    addr_d  = addr_i[ADDR_WIDTH+1:2];
                    wdata_d = data_i;
                    sel_d   = sel_i;
                    we_d    = we_i;
                    err_d   = range_err_c;
                    if (range_err_c) begin
                        state_d = RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = MEM;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = MEM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MEM: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request and registered-output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= '0;
            first_q     <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            err_q       <= err_d;
            ready_q     <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            rsp_err_q   <= (state_d == RESP) & err_d;
            // Only a read leaving MEM presents live SRAM data in its first RESP cycle
            first_q     <= (state_q == MEM) & ~we_q;
            if (req_hs_c) begin
                hold_q <= '0;
            end else if (first_q) begin
                hold_q <= mem_rdata_i;
            end
            if (state_d == MEM) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= we_d;
                mem_addr_q  <= addr_d;
                mem_wdata_q <= wdata_d;
                mem_sel_q   <= sel_d;
            end else begin
                mem_en_q    <= 1'b0;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
                mem_sel_q   <= '0;
            end
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_sel_o   = mem_sel_q;
    assign data_o      = rsp_valid_q ? (first_q ? mem_rdata_i : hold_q) : '0;

endmodule

// File: tb/tb_imem_rsp.sv
// Bench for imem_rsp: directed and random transactions against a word-level memory model,
// with latency, SRAM-port, backpressure and asynchronous-reset checks.
module tb_imem_rsp;

    localparam int unsigned AW    = 14;
    localparam int unsigned WAITC = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [31:0]   addr_i;
    logic [31:0]   data_i;
    logic [3:0]    sel_i;
    logic          we_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   data_o;
    logic          rsp_err_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_sel_o;
    logic [31:0]   mem_rdata_i;

    int checks   = 0;
    int failures = 0;

    // SRAM environment model plus a noise override used to disturb the read bus
    logic [31:0] sram [0:(1<<AW)-1];
    logic [31:0] sram_q = 32'h0;
    logic        noise_en = 1'b0;
    logic [31:0] noise = 32'h0;

    // Reference: what each word should contain, from the requests alone
    logic [31:0] ref_mem [logic [AW-1:0]];
    logic [AW-1:0] words [$];

    imem_rsp #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .data_o(data_o), .rsp_err_o(rsp_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_sel_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                sram_q <= sram[mem_addr_o];
            end
        end
    end

    assign mem_rdata_i = noise_en ? noise : sram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input logic we, input int hold);
        logic          err;
        logic [AW-1:0] word;
        logic [31:0]   exp_d, cur, m_wdata;
        logic [AW-1:0] m_addr;
        logic [3:0]    m_sel;
        logic          m_we;
        int            cyc, exp_lat, mem_cnt, mem_cyc, ready_bad, idle_bad;
        err   = |addr[31:AW+2];
        word  = addr[AW+1:2];
        exp_d = 32'h0;
        if (!err && !we) exp_d = ref_mem[word];
        if (!err && we) begin
            cur = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
            for (int b = 0; b < 4; b++) if (sel[b]) cur[8*b +: 8] = data[8*b +: 8];
            ref_mem[word] = cur;
        end
        exp_lat = err ? 1 : int'(WAITC) + 2;

        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready_o), 32'h1);
        req_valid_i = 1'b1; addr_i = addr; data_i = data; sel_i = sel; we_i = we;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        cyc = 1; mem_cnt = 0; mem_cyc = 0; ready_bad = 0; idle_bad = 0;
        m_addr = '0; m_we = 1'b0; m_wdata = 32'h0; m_sel = 4'h0;
        while (!rsp_valid_o && cyc < 20) begin
            if (mem_en_o) begin
                mem_cnt++; mem_cyc = cyc;
                m_addr = mem_addr_o; m_we = mem_we_o; m_wdata = mem_wdata_o; m_sel = mem_sel_o;
            end else if (mem_we_o || mem_addr_o != '0 || mem_wdata_o != 32'h0 || mem_sel_o != 4'h0) begin
                idle_bad++;
            end
            if (req_ready_o) ready_bad++;
            // Junk on request inputs and rsp_ready while busy must be ignored
            addr_i = $urandom; data_i = $urandom; sel_i = 4'($urandom); we_i = 1'($urandom);
            rsp_ready_i = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        req_valid_i = 1'b0;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("mem_en_count", 32'(mem_cnt), err ? 32'h0 : 32'h1);
        chk("ready_while_busy", 32'(ready_bad), 32'h0);
        chk("mem_idle_zero", 32'(idle_bad), 32'h0);
        if (!err) begin
            chk("mem_cycle", 32'(mem_cyc), 32'(WAITC + 1));
            chk("mem_addr", 32'(m_addr), 32'(word));
            chk("mem_we", 32'(m_we), 32'(we));
            chk("mem_wdata", m_wdata, data);
            chk("mem_sel", 32'(m_sel), 32'(sel));
        end
        chk("rsp_err", 32'(rsp_err_o), 32'(err));
        chk("rsp_data", data_o, exp_d);
        rsp_ready_i = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            noise_en = 1'b1; noise = $urandom;
            #1;
            chk("hold_valid", 32'(rsp_valid_o), 32'h1);
            chk("hold_data", data_o, exp_d);
            chk("hold_err", 32'(rsp_err_o), 32'(err));
            rsp_ready_i = (h == hold - 1);
        end
        @(negedge clk);
        chk("back_idle_valid", 32'(rsp_valid_o), 32'h0);
        chk("back_idle_ready", 32'(req_ready_o), 32'h1);
        chk("back_idle_data", data_o, 32'h0);
        noise_en = 1'b0; rsp_ready_i = 1'b0;
    endtask

    // Start a read, then pull reset after 'after' cycles; no response may follow
    task automatic rst_mid(input logic [AW-1:0] word, input int after);
        int bad;
        @(negedge clk);
        req_valid_i = 1'b1; addr_i = {16'h0, word, 2'b00}; we_i = 1'b0; sel_i = 4'hF;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (after - 1) @(negedge clk);
        chk("pre_rst_valid", 32'(rsp_valid_o), (after >= int'(WAITC) + 2) ? 32'h1 : 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid_o), 32'h0);
        chk("async_rst_mem_en", 32'(mem_en_o), 32'h0);
        chk("async_rst_ready", 32'(req_ready_o), 32'h0);
        chk("async_rst_data", data_o, 32'h0);
        chk("async_rst_err", 32'(rsp_err_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_ready_pre_edge", 32'(req_ready_o), 32'h0);
        @(negedge clk);
        chk("rel_ready", 32'(req_ready_o), 32'h1);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid_o || mem_en_o || !req_ready_o) bad++;
        end
        chk("no_stale_rsp", 32'(bad), 32'h0);
    endtask

    initial begin
        logic [AW-1:0] w;
        logic [31:0]   a;
        int            op;
        rst_n = 1'b1; req_valid_i = 1'b0; addr_i = '0; data_i = '0; sel_i = '0; we_i = 1'b0;
        rsp_ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_mem_en", 32'(mem_en_o), 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_err", 32'(rsp_err_o), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready_o), 32'h1);

        // Write then read back word 4
        txn(32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1, 0);
        words.push_back(AW'(4));
        txn(32'h0000_0010, 32'h0, 4'hF, 1'b0, 0);

        // Fill words 0..15 and the top word
        for (int i = 0; i < 16; i++) begin
            if (i != 4) begin
                txn({16'h0, AW'(i), 2'(i)}, $urandom, 4'hF, 1'b1, 0);
                words.push_back(AW'(i));
            end
        end
        txn({16'h0, {AW{1'b1}}, 2'b00}, $urandom, 4'hF, 1'b1, 0);
        words.push_back({AW{1'b1}});
        txn({16'h0, {AW{1'b1}}, 2'b11}, 32'h0, 4'hF, 1'b0, 1);

        txn(32'h0000_0004, 32'h0, 4'hF, 1'b0, 0);
        txn(32'h0000_0008, 32'hAABB_CCDD, 4'b0011, 1'b1, 0);
        txn(32'h0000_0008, 32'h0, 4'hF, 1'b0, 0);
        txn(32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, 1'b1, 0);
        txn(32'h0000_000B, 32'h0, 4'hF, 1'b0, 2);

        // Out-of-range accesses, first byte beyond the top and far above
        txn(32'h0001_0000, 32'h0, 4'hF, 1'b0, 0);
        txn(32'hFFFF_FFF0, 32'hDEAD_BEEF, 4'hF, 1'b1, 1);
        txn(32'h0000_FFFC, 32'h0, 4'hF, 1'b0, 0);

        // Backpressure with the read bus toggling
        txn(32'h0000_0014, 32'h0, 4'hF, 1'b0, 4);

        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 5));
            w  = words[$urandom_range(0, words.size() - 1)];
            a  = {16'h0, w, 2'($urandom)};
            if (op <= 2)      txn(a, $urandom, 4'($urandom), 1'b0, int'($urandom_range(0, 3)));
            else if (op <= 4) txn(a, $urandom, 4'($urandom), 1'b1, int'($urandom_range(0, 3)));
            else              txn({16'($urandom_range(1, 16'hFFFF)), 16'($urandom)}, $urandom,
                                  4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        rst_mid(AW'(3), 2);
        rst_mid(AW'(5), int'(WAITC) + 2);
        txn(32'h0000_000C, 32'h0, 4'hF, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_rsp.md
IMEM_RSP -- requirements
Module: imem_rsp

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, SHALL give the word-address bits decoded (memory depth 2^ADDR_WIDTH words).
REQ-002 Parameter WAIT_CYCLES, default 0, range 0..7, SHALL give the extra wait cycles inserted before each memory access.
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  req_valid_i  in  1  initiator request valid.
  req_ready_o  out  1  responder can accept a request.
  addr_i  in  32  byte address.
  data_i  in  32  write data.
  sel_i  in  4  byte enables.
  we_i  in  1  1 = write, 0 = read.
  rsp_valid_o  out  1  response valid.
  rsp_ready_i  in  1  initiator accepts the response.
  data_o  out  32  read data.
  rsp_err_o  out  1  address out of range.
  mem_en_o  out  1  synchronous SRAM enable.
  mem_we_o  out  1  SRAM write enable.
  mem_addr_o  out  ADDR_WIDTH  SRAM word address.
  mem_wdata_o  out  32  SRAM write data.
  mem_sel_o  out  4  SRAM byte enables.
  mem_rdata_i  in  32  SRAM read data, valid the cycle after mem_en_o.

Function
REQ-004 FSM states SHALL be IDLE, WAIT, MEM and RESP. Exactly one request SHALL be outstanding at a time.
REQ-005 req_ready_o SHALL be 1 only in IDLE. A request handshake is req_valid_i & req_ready_o.
REQ-006 On a request handshake the block SHALL latch addr_i[ADDR_WIDTH+1:2], data_i, sel_i and we_i, and SHALL latch range_err = |addr_i[31:ADDR_WIDTH+2].
REQ-007 Transitions out of IDLE on handshake:
  range_err=1 -> RESP.
  else WAIT_CYCLES>0 -> WAIT, with the 3-bit wait counter loaded to WAIT_CYCLES-1.
  else -> MEM.
REQ-008 WAIT: the counter SHALL decrement each cycle; at 0 the next state SHALL be MEM.
REQ-009 MEM: this state SHALL last exactly 1 cycle.
  - mem_en_o=1; mem_addr_o, mem_we_o, mem_wdata_o and mem_sel_o SHALL come from the latched request.
  - The next state SHALL be RESP.
  - mem_en_o SHALL be 0 in every other state.
REQ-010 RESP: rsp_valid_o=1, held with data_o and rsp_err_o stable until rsp_valid_o & rsp_ready_i. On that handshake the next state SHALL be IDLE.
REQ-011 Read data in RESP:
  - First RESP cycle after MEM: data_o = mem_rdata_i, and the same value SHALL be captured into a hold register.
  - Later RESP cycles: data_o = the hold register.
REQ-012 For writes and for range errors, data_o SHALL be 32'h0. rsp_err_o SHALL equal the latched range_err.
REQ-013 A range-error request SHALL NOT assert mem_en_o.
REQ-014 addr_i[1:0] SHALL be ignored. A write with sel_i=0 SHALL still perform the MEM cycle, with mem_sel_o=0.
REQ-015 Read latency, request handshake to first rsp_valid_o: WAIT_CYCLES+2 cycles. Range error: 1 cycle.
REQ-016 Outside RESP: rsp_valid_o=0 and data_o=0. mem_* outputs SHALL be 0 whenever mem_en_o=0.
REQ-017 rsp_ready_i SHALL be ignored outside RESP. req_valid_i SHALL be ignored outside IDLE; no request is accepted while a response is pending.

Reset
REQ-018 rst_n low SHALL immediately force:
  - FSM = IDLE, wait counter = 0, latched request = 0, hold register = 0.
  - rsp_valid_o=0, rsp_err_o=0, data_o=0, mem_en_o=0, req_ready_o=0.
REQ-019 req_ready_o SHALL be 1 from the first clock edge after rst_n rises.
REQ-020 Reset asserted in any state, including mid-WAIT or mid-RESP, SHALL abandon the request with no response issued.

Verification
REQ-021 WAIT_CYCLES=0; write 0x1234_5678 to addr 0x10, sel=4'hF, then read addr 0x10 with rsp_ready_i=1 -> mem_en_o at handshake+1; rsp_valid_o at handshake+2 with data_o=0x1234_5678, rsp_err_o=0.
REQ-022 WAIT_CYCLES=3; read addr 0x4 -> mem_en_o at handshake+4, rsp_valid_o at handshake+5, req_ready_o=0 throughout.
REQ-023 Read, then hold rsp_ready_i=0 for 4 cycles -> rsp_valid_o stays 1 and data_o stays stable while mem_rdata_i is toggled; returns to IDLE one cycle after rsp_ready_i=1.
REQ-024 ADDR_WIDTH=14; read addr 0x0001_0000 -> no mem_en_o; rsp_valid_o at handshake+1 with rsp_err_o=1 and data_o=0.
REQ-025 Write addr 0x8, sel=4'b0011, data 0xAABB_CCDD -> mem_addr_o=2, mem_sel_o=4'b0011, mem_we_o=1 for exactly 1 cycle; response data_o=0.
REQ-026 rst_n pulsed low during WAIT (WAIT_CYCLES=5) -> rsp_valid_o and mem_en_o go 0 asynchronously; after release, req_ready_o=1 and no stale response is issued.
